data_mem_ws: RTL and testbench

Parametrised byte-addressed, big-endian data memory for the MIPS datapath, the successor to the fixed 256-byte word-only data memory. It adds:
- byte, halfword and word access, with sign or zero extension on loads
- alignment and range checking
- a request/ready handshake with a configurable number of wait states, so the pipeline can be tested against slow memory

It sits in the MEM stage. A stall is derived from Ready.

---
 rtl/data_mem_ws.sv | 164 ++++++++++++++++
 tb/tb_data_mem_ws.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ws.sv
// data_mem_ws
// Byte-addressed, big-endian data memory for the MIPS MEM stage with a
// request/ready handshake and a configurable number of wait states.
// Supports byte, halfword and word access. Loads are sign- or
// zero-extended. Misaligned, out-of-range and malformed requests are
// rejected.
//
// Parameters:
//   ADDR_W      byte-address bits decoded (depth = 2**ADDR_W bytes, ADDR_W 3..31)
//   WAIT_CYCLES extra cycles between accept and response (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Req        request strobe, accepted on a rising edge while Ready=1
//   MemWrite   store request
//   MemRead    load request
//   Size       00 byte, 01 halfword, 10 word, 11 illegal
//   Unsigned   1 zero-extends loads, 0 sign-extends them
//   Address    byte address
//   WriteData  store data, right-justified for byte and halfword
//   Ready      block can accept a request this cycle
//   RespValid  one-cycle response strobe
//   ReadData   load result, zero unless RespValid=1
//   Error      request rejected, zero unless RespValid=1
module data_mem_ws #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Ready,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        Error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [7:0]        mem [DEPTH];
    state_t            state, next_state;
    logic [3:0]        count, next_count;
    logic              accept, reject, store_en;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       load_value;
    logic [31:0]       hold_data;
    logic              hold_err;

    assign Ready  = (state != WAIT);
    assign accept = Req && Ready;
    // rst_n gates the store so nothing is written while reset is held.
    assign store_en = accept && MemWrite && !reject && rst_n;

    // Byte lanes of the access. Alignment checks guarantee that for legal
    // halfword/word accesses the low bits are zero, so the following bytes
    // are formed by setting low bits instead of adding.
    assign a0 = Address[ADDR_W-1:0];
    assign a1 = {a0[ADDR_W-1:1], 1'b1};
    assign a2 = {a0[ADDR_W-1:2], 2'b10};
    assign a3 = {a0[ADDR_W-1:2], 2'b11};

    // Any single violation rejects the whole request.
    always_comb begin
        reject = 1'b0;
        if (Size == 2'b11)                           reject = 1'b1;
        if (Size == 2'b01 && Address[0])             reject = 1'b1;
        if (Size == 2'b10 && Address[1:0] != 2'b00)  reject = 1'b1;
        if (Address[31:ADDR_W] != '0)                reject = 1'b1;
        if (MemRead && MemWrite)                     reject = 1'b1;
    end

    // Big-endian read with extension; captured into the hold register on
    // accept. Zero for stores, no-ops and rejected requests.
    always_comb begin
        load_value = '0;
        case (Size)
            2'b00:   load_value = {{24{~Unsigned & mem[a0][7]}}, mem[a0]};
            2'b01:   load_value = {{16{~Unsigned & mem[a0][7]}}, mem[a0], mem[a1]};
            2'b10:   load_value = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: load_value = '0;
        endcase
        if (!MemRead || reject) load_value = '0;
    end

    // Storage is not reset; stores commit on the accept edge so a load
    // accepted on the following edge already sees the new bytes.
    always_ff @(posedge clk) begin
        if (store_en) begin
            case (Size)
                2'b00: mem[a0] <= WriteData[7:0];
                2'b01: begin
                    mem[a0] <= WriteData[15:8];
                    mem[a1] <= WriteData[7:0];
                end
                2'b10: begin
                    mem[a0] <= WriteData[31:24];
                    mem[a1] <= WriteData[23:16];
                    mem[a2] <= WriteData[15:8];
                    mem[a3] <= WriteData[7:0];
                end
                default: ;
            endcase
        end
    end

    // State, wait counter and response hold register. Reset discards any
    // pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (accept) begin
                hold_data <= load_value;
                hold_err  <= reject;
            end
        end
    end

    // Accepts are allowed from IDLE and from RESP, so back-to-back requests
    // run at one per cycle when there are no wait states.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_count = WAIT_LOAD;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (count == 4'd0) next_state = RESP;
                else               next_count = count - 4'd1;
            end
            default: next_state = IDLE;
        endcase
    end

    assign RespValid = (state == RESP);
    assign ReadData  = RespValid ? hold_data : 32'd0;
    assign Error     = RespValid ? hold_err  : 1'b0;

endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws
// Testbench for data_mem_ws. Two instances are used: dut0 with no wait
// states and dut3 with three. Shared stimulus is steered to one of them
// by sel, and their outputs are muxed back the same way. A byte-array
// reference model per instance predicts every response.
module tb_data_mem_ws;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    bit          sel = 1'b0;

    logic        req0, req3;
    logic        ready0, resp0, err0, ready3, resp3, err3;
    logic [31:0] rdata0, rdata3;
    logic        ready_o, resp_o, err_o;
    logic [31:0] rdata_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_mem [2][256];

    assign req0    = req & ~sel;
    assign req3    = req & sel;
    assign ready_o = sel ? ready3 : ready0;
    assign resp_o  = sel ? resp3  : resp0;
    assign err_o   = sel ? err3   : err0;
    assign rdata_o = sel ? rdata3 : rdata0;

    always #5 clk = ~clk;

    data_mem_ws #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Req(req0), .MemWrite(mem_write),
        .MemRead(mem_read), .Size(size), .Unsigned(uns), .Address(addr),
        .WriteData(wdata), .Ready(ready0), .RespValid(resp0),
        .ReadData(rdata0), .Error(err0)
    );

    data_mem_ws #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .Req(req3), .MemWrite(mem_write),
        .MemRead(mem_read), .Size(size), .Unsigned(uns), .Address(addr),
        .WriteData(wdata), .Ready(ready3), .RespValid(resp3),
        .ReadData(rdata3), .Error(err3)
    );

    function automatic int lat_of(bit s);
        return s ? 4 : 1;
    endfunction

    // Transaction-level reference: applies a request to the model memory
    // and returns the response it should produce.
    function automatic void model_access(input bit s, input logic wr, input logic rd,
                                         input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] data, output logic err);
        int n;
        logic [31:0] v;
        n    = 1 << sz;
        err  = (sz == 2'd3) || (a > 32'd255) || ((a % n) != 0) || (rd && wr);
        data = 32'd0;
        if (!err && wr)
            for (int i = 0; i < n; i++)
                model_mem[s][int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
        if (!err && rd) begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | 32'(model_mem[s][int'(a) + i]);
            if (!u && n < 4 && v[8 * n - 1])
                v = v | ~((32'd1 << (8 * n)) - 32'd1);
            data = v;
        end
    endfunction

    task automatic rand_req(output logic wr, output logic rd, output logic [1:0] sz,
                            output logic u, output logic [31:0] a, output logic [31:0] wd);
        int k;
        k  = $urandom_range(0, 9);
        sz = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
        k  = $urandom_range(0, 9);
        rd = (k < 4) || (k == 9);
        wr = (k >= 4 && k < 8) || (k == 9);
        u  = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
        wd = $urandom;
    endtask

    // One complete request/response on the selected instance. With hold
    // set, Req stays high through the wait states to prove it is ignored.
    task automatic do_req(input string name, input logic wr, input logic rd,
                          input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold,
                          output logic [31:0] got, output logic got_err);
        logic [31:0] exp_data;
        logic        exp_err;
        int lat, low, spin;
        model_access(sel, wr, rd, sz, u, a, wd, exp_data, exp_err);
        req = 1'b1; mem_write = wr; mem_read = rd; size = sz; uns = u;
        addr = a; wdata = wd;
        spin = 0;
        while (ready_o !== 1'b1 && spin < 50) begin
            @(posedge clk); #1; spin++;
        end
        if (spin >= 50) begin
            checks++; failures++;
            $display("[TB] FAIL %s ready_timeout: got %b expected 1", name, ready_o);
            req = 1'b0; got = 32'd0; got_err = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        lat = 1; low = 0;
        while (resp_o !== 1'b1 && lat <= 40) begin
            if (ready_o === 1'b0) low++;
            checks++;
            if (rdata_o !== 32'd0 || err_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s idle_outputs: got %h/%b expected 0/0", name, rdata_o, err_o);
            end
            @(posedge clk); #1; lat++;
        end
        req = 1'b0;
        got = rdata_o; got_err = err_o;
        checks++;
        if (lat !== lat_of(sel)) begin
            failures++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, lat_of(sel));
        end
        checks++;
        if (low !== lat_of(sel) - 1) begin
            failures++;
            $display("[TB] FAIL %s ready_low_cycles: got %0d expected %0d", name, low, lat_of(sel) - 1);
        end
        checks++;
        if (rdata_o !== exp_data) begin
            failures++;
            $display("[TB] FAIL %s read_data: got %h expected %h", name, rdata_o, exp_data);
        end
        checks++;
        if (err_o !== exp_err) begin
            failures++;
            $display("[TB] FAIL %s error: got %b expected %b", name, err_o, exp_err);
        end
        if (hold) begin
            repeat (6) begin
                @(posedge clk); #1;
                checks++;
                if (resp_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s double_accept: got %b expected 0", name, resp_o);
                end
            end
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (ready_o !== 1'b1 || resp_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got ready=%b resp=%b data=%h err=%b expected 1/0/0/0",
                     name, ready_o, resp_o, rdata_o, err_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; check_quiet("reset_held_dut0");
        sel = 1'b1; check_quiet("reset_held_dut3");
        rst_n = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0; check_quiet("after_reset_dut0");
        sel = 1'b1; check_quiet("after_reset_dut3");
    endtask

    // Write known zeros everywhere so the bench never relies on power-up contents.
    task automatic test_init();
        logic [31:0] d;
        logic e;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < 64; w++)
                do_req("init", 1'b1, 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0, 1'b0, d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic e;
        sel = 1'b0;
        req = 1'b1; mem_write = 1'b1; mem_read = 1'b0; size = 2'd2; uns = 1'b0;
        addr = 32'h14; wdata = 32'hDEADBEEF;
        model_access(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, d, e);
        @(posedge clk); #1;
        checks++;
        if (resp_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'd0) begin
            failures++;
            $display("[TB] FAIL b2b_store_resp: got %b/%b/%h expected 1/0/00000000", resp_o, err_o, rdata_o);
        end
        mem_write = 1'b0; mem_read = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL b2b_load_resp: got %b/%b/%h expected 1/0/deadbeef", resp_o, err_o, rdata_o);
        end
        req = 1'b0;
        @(posedge clk); #1;
        check_quiet("b2b_after");
    endtask

    task automatic test_extension();
        logic [31:0] d;
        logic e;
        logic [31:0] exp_tab [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF,
                                     32'hDE5ABEEF, 32'hDE5A1234, 32'h00001234};
        sel = 1'b0;
        do_req("ld_b_s", 1'b0, 1'b1, 2'd0, 1'b0, 32'h14, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[0]) begin failures++; $display("[TB] FAIL ld_b_s_const: got %h expected %h", d, exp_tab[0]); end
        do_req("ld_b_u", 1'b0, 1'b1, 2'd0, 1'b1, 32'h14, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[1]) begin failures++; $display("[TB] FAIL ld_b_u_const: got %h expected %h", d, exp_tab[1]); end
        do_req("ld_h_s", 1'b0, 1'b1, 2'd1, 1'b0, 32'h16, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[2]) begin failures++; $display("[TB] FAIL ld_h_s_const: got %h expected %h", d, exp_tab[2]); end
        do_req("st_b", 1'b1, 1'b0, 2'd0, 1'b0, 32'h15, 32'h0000005A, 1'b0, d, e);
        do_req("ld_w_a", 1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[3]) begin failures++; $display("[TB] FAIL st_b_word_const: got %h expected %h", d, exp_tab[3]); end
        do_req("st_h", 1'b1, 1'b0, 2'd1, 1'b0, 32'h16, 32'hCAFE1234, 1'b0, d, e);
        do_req("ld_w_b", 1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[4]) begin failures++; $display("[TB] FAIL st_h_word_const: got %h expected %h", d, exp_tab[4]); end
        do_req("ld_h_u", 1'b0, 1'b1, 2'd1, 1'b1, 32'h16, 32'd0, 1'b0, d, e);
        checks++; if (d !== exp_tab[5]) begin failures++; $display("[TB] FAIL ld_h_u_const: got %h expected %h", d, exp_tab[5]); end
    endtask

    // Each rejected store is followed by a word load of the region it
    // would have touched, which must be unchanged.
    task automatic test_errors();
        logic [31:0] d;
        logic e;
        logic        ew   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        er   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  es   [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
        logic [31:0] ea   [5] = '{32'h02, 32'h01, 32'h14, 32'h100, 32'h14};
        logic [31:0] fa   [5] = '{32'h00, 32'h00, 32'h14, 32'h00, 32'h14};
        logic [31:0] fexp [5] = '{32'h0, 32'h0, 32'hDE5A1234, 32'h0, 32'hDE5A1234};
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_req("err_req", ew[i], er[i], es[i], 1'b0, ea[i], 32'hFFFFFFFF, 1'b0, d, e);
            checks++;
            if (e !== 1'b1 || d !== 32'd0) begin
                failures++;
                $display("[TB] FAIL err_const[%0d]: got %b/%h expected 1/00000000", i, e, d);
            end
            do_req("err_follow", 1'b0, 1'b1, 2'd2, 1'b0, fa[i], 32'd0, 1'b0, d, e);
            checks++;
            if (d !== fexp[i]) begin
                failures++;
                $display("[TB] FAIL err_mem_unchanged[%0d]: got %h expected %h", i, d, fexp[i]);
            end
        end
        do_req("noop", 1'b0, 1'b0, 2'd2, 1'b0, 32'h14, 32'hFFFFFFFF, 1'b0, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'd0) begin
            failures++;
            $display("[TB] FAIL noop_const: got %b/%h expected 0/00000000", e, d);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] d;
        logic e;
        sel = 1'b1;
        do_req("ws_store", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'hA1B2C3D4, 1'b0, d, e);
        do_req("ws_load_hold", 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, d, e);
        checks++;
        if (d !== 32'hA1B2C3D4) begin
            failures++;
            $display("[TB] FAIL ws_load_const: got %h expected a1b2c3d4", d);
        end
    endtask

    task automatic test_random_single();
        logic wr, rd, u;
        logic [1:0] sz;
        logic [31:0] a, wd, d;
        logic e;
        for (int i = 0; i < 160; i++) begin
            sel = 1'(i % 2);
            rand_req(wr, rd, sz, u, a, wd);
            do_req("rand", wr, rd, sz, u, a, wd, 1'b0, d, e);
        end
    endtask

    // Random stream at up to one request per cycle on the zero-wait instance.
    task automatic test_random_b2b();
        logic wr, rd, u;
        logic [1:0] sz;
        logic [31:0] a, wd, exp_d;
        logic exp_e;
        bit exp_v;
        sel = 1'b0;
        for (int i = 0; i < 150; i++) begin
            rand_req(wr, rd, sz, u, a, wd);
            exp_v = ($urandom_range(0, 3) != 0);
            req = exp_v; mem_write = wr; mem_read = rd; size = sz; uns = u;
            addr = a; wdata = wd;
            exp_d = 32'd0; exp_e = 1'b0;
            if (exp_v) model_access(1'b0, wr, rd, sz, u, a, wd, exp_d, exp_e);
            checks++;
            if (ready_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_rand_ready: got %b expected 1", ready_o);
            end
            @(posedge clk); #1;
            checks++;
            if (resp_o !== exp_v || rdata_o !== exp_d || err_o !== exp_e) begin
                failures++;
                $display("[TB] FAIL b2b_rand[%0d]: got %b/%h/%b expected %b/%h/%b",
                         i, resp_o, rdata_o, err_o, exp_v, exp_d, exp_e);
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic e;
        sel = 1'b1;
        model_access(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h28, 32'h11223344, d, e);
        req = 1'b1; mem_write = 1'b1; mem_read = 1'b0; size = 2'd2; uns = 1'b0;
        addr = 32'h28; wdata = 32'h11223344;
        @(posedge clk); #1;
        req = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || resp_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_wait: got ready=%b resp=%b expected 0/0", ready_o, resp_o);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (resp_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rstmid_early_resp: got %b expected 0", resp_o);
            end
        end
        rst_n = 1'b0;
        #1;
        check_quiet("rstmid_in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check_quiet("rstmid_after_release");
        end
        do_req("rstmid_load", 1'b0, 1'b1, 2'd2, 1'b0, 32'h28, 32'd0, 1'b0, d, e);
        checks++;
        if (d !== 32'h11223344) begin
            failures++;
            $display("[TB] FAIL rstmid_load_const: got %h expected 11223344", d);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                model_mem[s][i] = 8'h00;
        test_reset();
        test_init();
        test_back_to_back();
        test_extension();
        test_errors();
        test_wait_states();
        test_random_single();
        test_random_b2b();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
